// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b memory-path types for the I/D physical-memory arbiter.
// Latency: none (types and helpers only); backpressure: n/a.
package pmem_arbiter_pkg;

    typedef logic [15:0]  lc3b_pmem_addr;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/pmem_arbiter_rr_select.sv
// Two-way round-robin pick between I and D requesters.
// Latency: combinational; backpressure: none, caller decides when to act on the pick.
module rr_select
    import pmem_arbiter_pkg::*;
(
    input  arb_port_t last_grant,
    input  logic      i_active,
    input  logic      d_active,
    output logic      grant_vld,
    output arb_port_t grant_port
);

    always_comb begin
        grant_vld  = i_active | d_active;
        grant_port = PORT_I;
        // On contention the port served least recently wins.
        if (i_active && d_active) begin
            grant_port = other_port(last_grant);
        end else if (d_active) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache controllers.
// Latency: request in IDLE gives a strobe next cycle; the requester stalls on its resp until memory answers.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = $bits(lc3b_pmem_addr),
    parameter int LINE_WIDTH = $bits(lc3b_cacheline)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic                  i_pmem_resp,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic                  d_pmem_resp,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy
);

    arb_state_t            state_q, state_d;
    arb_port_t             last_grant_q, last_grant_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic      i_active, d_active;
    logic      grant_vld;
    arb_port_t grant_port;

    assign i_active = i_pmem_read | i_pmem_write;
    assign d_active = d_pmem_read | d_pmem_write;

    rr_select u_rr_select (
        .last_grant (last_grant_q),
        .i_active   (i_active),
        .d_active   (d_active),
        .grant_vld  (grant_vld),
        .grant_port (grant_port)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = SERVE;
                    last_grant_d = grant_port;
                    // A port raising read and write together is treated as a write.
                    if (grant_port == PORT_D) begin
                        op_write_d = d_pmem_write;
                        addr_d     = d_pmem_address;
                        wdata_d    = d_pmem_wdata;
                    end else begin
                        op_write_d = i_pmem_write;
                        addr_d     = i_pmem_address;
                        wdata_d    = i_pmem_wdata;
                    end
                end
            end
            SERVE: begin
                pmem_read  = ~op_write_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    state_d     = RELEASE;
                    i_pmem_resp = (last_grant_q == PORT_I);
                    d_pmem_resp = (last_grant_q == PORT_D);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign busy         = (state_q != IDLE);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised and directed bench for pmem_arbiter against a transaction-timeline model.
// Latency: n/a; backpressure: memory model answers after a programmable or random delay.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [15:0]  i_pmem_address, d_pmem_address, pmem_address;
    logic [127:0] i_pmem_wdata, d_pmem_wdata, pmem_wdata, pmem_rdata;
    logic [127:0] i_pmem_rdata, d_pmem_rdata;
    logic         i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp, busy;

    pmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Stimulus controls, owned by the initial block.
    bit auto_en, rand_dly, done_req;
    int fix_dly, spur_pct, req_pct, mem_cnt, mem_dly, tmo_cnt;
    int i_seen, d_seen;

    // Model and checker state, owned by the negedge process.
    int           n_chk, n_err, n_txn, i_resp_cnt, d_resp_cnt;
    int           ph_prev, cur_ph;
    bit           cur_d, final_done;
    bit           snap_rst, snap_i_act, snap_d_act, snap_i_wr, snap_d_wr;
    logic [15:0]  snap_i_addr, snap_d_addr, m_addr;
    logic [127:0] snap_i_wdata, snap_d_wdata, m_wdata;
    bit           last_was_d, m_d, m_wr;

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Phases of the model timeline: 0 idle, 1 serving, 2 response cycle, 3 release.
    always @(negedge clk) begin
        int ph;
        assert (!(i_pmem_read && i_pmem_write));
        assert (!(d_pmem_read && d_pmem_write));
        ph = 0;
        if (!snap_rst) begin
            ph = 0; last_was_d = 1'b0; m_wr = 1'b0; m_d = 1'b0;
            m_addr = '0; m_wdata = '0;
        end else if (ph_prev == 1) begin
            ph = 1;
        end else if (ph_prev == 2) begin
            ph = 3;
        end else if (ph_prev == 0 && (snap_i_act || snap_d_act)) begin
            // Ties go to whichever port was not served most recently.
            m_d = (snap_i_act && snap_d_act) ? !last_was_d : snap_d_act;
            last_was_d = m_d;
            m_wr    = m_d ? snap_d_wr : snap_i_wr;
            m_addr  = m_d ? snap_d_addr : snap_i_addr;
            m_wdata = m_d ? snap_d_wdata : snap_i_wdata;
            ph = 1;
        end
        if (ph == 1 && pmem_resp) ph = 2;

        chk("busy",         128'(busy),         128'(ph != 0));
        chk("pmem_read",    128'(pmem_read),    128'((ph == 1 || ph == 2) && !m_wr));
        chk("pmem_write",   128'(pmem_write),   128'((ph == 1 || ph == 2) && m_wr));
        chk("pmem_address", 128'(pmem_address), 128'(m_addr));
        chk("pmem_wdata",   pmem_wdata,         m_wdata);
        chk("i_resp",       128'(i_pmem_resp),  128'(ph == 2 && !m_d));
        chk("d_resp",       128'(d_pmem_resp),  128'(ph == 2 && m_d));
        chk("i_rdata",      i_pmem_rdata,       pmem_rdata);
        chk("d_rdata",      d_pmem_rdata,       pmem_rdata);

        if (ph == 2) n_txn++;
        if (i_pmem_resp) i_resp_cnt++;
        if (d_pmem_resp) d_resp_cnt++;
        if (done_req && !final_done) begin
            final_done = 1'b1;
            chk("txn_count", 128'(n_txn >= 100), 128'(1));
            chk("timeouts",  128'(tmo_cnt),      128'(0));
        end

        ph_prev = ph; cur_ph = ph; cur_d = m_d;
        snap_rst = rst_n;
        snap_i_act = i_pmem_read | i_pmem_write; snap_i_wr = i_pmem_write;
        snap_d_act = d_pmem_read | d_pmem_write; snap_d_wr = d_pmem_write;
        snap_i_addr = i_pmem_address; snap_i_wdata = i_pmem_wdata;
        snap_d_addr = d_pmem_address; snap_d_wdata = d_pmem_wdata;
    end

    task automatic new_req(input bit is_d);
        bit w;
        w = ($urandom_range(0, 3) == 0);
        if (is_d) begin
            d_pmem_write = w; d_pmem_read = !w;
            d_pmem_address = 16'($urandom); d_pmem_wdata = rnd_line();
        end else begin
            i_pmem_write = w; i_pmem_read = !w;
            i_pmem_address = 16'($urandom); i_pmem_wdata = rnd_line();
        end
    endtask

    // One clock: memory model, then autonomous requesters; all drives land 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pmem_read || pmem_write) begin
            if (mem_cnt >= mem_dly) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rand_dly ? rnd_line() : 128'hDEAD0000_00000000_00000000_0000BEEF;
            end else begin
                pmem_resp = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_cnt    = 0;
            mem_dly    = rand_dly ? int'($urandom_range(0, 3)) : fix_dly;
            pmem_resp  = (int'($urandom_range(0, 99)) < spur_pct);
            pmem_rdata = rnd_line();
        end
        if (auto_en) begin
            if (i_resp_cnt != i_seen) begin
                i_seen = i_resp_cnt; i_pmem_read = 1'b0; i_pmem_write = 1'b0;
            end
            if (d_resp_cnt != d_seen) begin
                d_seen = d_resp_cnt; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
            end
            if (!(i_pmem_read || i_pmem_write)) begin
                if (int'($urandom_range(0, 99)) < req_pct) new_req(1'b0);
            end else if (cur_ph == 1 && !cur_d && $urandom_range(0, 2) == 0) begin
                i_pmem_address = 16'($urandom); i_pmem_wdata = rnd_line();
            end
            if (!(d_pmem_read || d_pmem_write)) begin
                if (int'($urandom_range(0, 99)) < req_pct) new_req(1'b1);
            end else if (cur_ph == 1 && cur_d && $urandom_range(0, 2) == 0) begin
                d_pmem_address = 16'($urandom); d_pmem_wdata = rnd_line();
            end
        end
    endtask

    task automatic wait_resp(input bit is_d);
        int c0;
        bit seen;
        c0 = is_d ? d_resp_cnt : i_resp_cnt;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            seen = ((is_d ? d_resp_cnt : i_resp_cnt) != c0);
        end
        if (!seen) tmo_cnt++;
    endtask

    initial begin
        i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
        auto_en = 0; rand_dly = 0; fix_dly = 0; spur_pct = 0; req_pct = 0;

        // Reset held with a D read pending, then released.
        d_pmem_read = 1; d_pmem_address = 16'h0100;
        repeat (3) step();
        rst_n = 1;
        wait_resp(1'b1);
        d_pmem_read = 0;
        repeat (2) step();

        // Single I read with a slow memory.
        fix_dly = 4;
        i_pmem_read = 1; i_pmem_address = 16'h1230;
        wait_resp(1'b0);
        i_pmem_read = 0;
        repeat (2) step();

        // Fresh reset, then simultaneous requests: D must go first.
        rst_n = 0; step(); rst_n = 1;
        fix_dly = 1;
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        d_pmem_write = 1; d_pmem_address = 16'h8010; d_pmem_wdata = {16{8'hA5}};
        wait_resp(1'b1);
        d_pmem_write = 0;
        wait_resp(1'b0);
        i_pmem_read = 0;
        repeat (2) step();

        // Address and data changes mid-transfer must not reach memory.
        fix_dly = 5;
        d_pmem_write = 1; d_pmem_address = 16'h3000; d_pmem_wdata = rnd_line();
        repeat (2) step();
        d_pmem_address = 16'h4000; d_pmem_wdata = rnd_line();
        wait_resp(1'b1);
        d_pmem_write = 0;
        repeat (2) step();

        // Spurious memory responses while idle.
        spur_pct = 100;
        repeat (4) step();
        spur_pct = 0;

        // Reset in the middle of a transfer.
        fix_dly = 8;
        d_pmem_read = 1; d_pmem_address = 16'h5550;
        repeat (3) step();
        rst_n = 0; d_pmem_read = 0;
        step();
        rst_n = 1;
        repeat (3) step();

        // Saturation: both ports always re-request.
        i_seen = i_resp_cnt; d_seen = d_resp_cnt;
        rand_dly = 1; req_pct = 100; auto_en = 1;
        repeat (200) step();

        // Random traffic with spurious responses and occasional resets.
        req_pct = 40; spur_pct = 10;
        repeat (3000) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1;
        repeat (5) step();

        done_req = 1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
